mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one single-port program/data memory between two requesters: the 6502 core (CPU port) and the program loader/debug DMA port (DMA port).
- Sequences every access through a fixed issue/wait/complete sequence and captures read data.
- Returns data with a one-cycle ack pulse.
- Sits between the CPU/loader and the memory model; the memory side uses 6502 rW convention (1 = read, 0 = write).

Parameters:
- ADDR_W, 16, address width on all ports.
- DATA_W, 8, data width on all ports.
- MEM_LATENCY, 1, cycles from mem_en issue to valid mem_rdata. Legal range 1..4; other values unsupported.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU access request; held with cpu_addr/cpu_rW/cpu_wdata stable until cpu_ack.
- cpu_rW  input  1  1 = read, 0 = write.
- cpu_addr  input  ADDR_W  CPU address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  read data, valid while cpu_ack=1, held until next CPU read completes.
- dma_req, dma_rW, dma_addr, dma_wdata, dma_ack, dma_rdata: same directions, widths and meanings as the CPU port, for the DMA requester.
- mem_address  output  ADDR_W  registered memory address.
- mem_rW  output  1  registered memory direction.
- mem_wdata  output  DATA_W  registered write data.
- mem_en  output  1  access strobe, high exactly one cycle per access.
- mem_rdata  input  DATA_W  memory read data.
- owner  output  1  0 = CPU, 1 = DMA; current or most recent grant.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_address=0, mem_wdata=0, mem_rW=1, mem_en=0.
  - cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0.
  - owner=0, busy=0.
  - Round-robin last-grant register = DMA.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at the clock edge, select the winner.
  - Latch the winner's addr/rW/wdata into mem_address/mem_rW/mem_wdata; set owner; go to ISSUE.
  - Otherwise stay in IDLE; mem_* outputs hold their last values.
- ISSUE: mem_en=1 for this single cycle; load wait counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the final WAIT cycle (cycle ISSUE+MEM_LATENCY), register mem_rdata into the winner's rdata register if mem_rW=1; go to DONE.
  - For writes, rdata registers are untouched.
- DONE: assert the winner's ack for exactly one cycle; go to IDLE.
- Latency: req sampled in IDLE at cycle T0 gives ack in cycle T0+2+MEM_LATENCY (T3 for MEM_LATENCY=1). Reads and writes have identical timing.
- Handshake:
  - A requester may drop req, or present a new request, on the edge that samples ack.
  - Req still high in the IDLE cycle after DONE is treated as a new request, so back-to-back accesses are legal.
  - Peak throughput: one access per 3+MEM_LATENCY cycles.
- Arbitration (default, macro off): fixed priority, CPU wins when both requests are high. The DMA can be starved by continuous CPU traffic; this is intended behaviour.
- Changes to a req or its payload in any non-IDLE state are ignored; the payload was latched in IDLE.
- The non-owner's ack is never asserted. The two acks are never high together.
- Address passes through unmodified; no width truncation or wrap inside this block.
- Reset mid-access:
  - The access is aborted immediately; mem_en drops asynchronously.
  - No ack is produced.
  - rdata registers reset to 0.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant goes to the requester not in the last-grant register. The register updates in IDLE on each grant. The first contention after reset goes to the CPU. A lone request is always granted immediately.
- Undefined: fixed CPU priority; the last-grant register is not implemented.

Test Plan:
- CPU read, MEM_LATENCY=1:
  - Stimulus: cpu_req=1, cpu_rW=1, cpu_addr=16'h0002; memory returns 8'h69.
  - Required: mem_en high in cycle 1 with mem_address=16'h0002; cpu_ack in cycle 3 with cpu_rdata=8'h69; dma_ack stays 0.
- DMA write:
  - Stimulus: dma_addr=16'h0005, dma_wdata=8'h4C, dma_rW=0.
  - Required: mem_rW=0 and mem_wdata=8'h4C during the mem_en cycle; dma_ack in cycle 3; cpu_rdata unchanged; owner=1.
- Simultaneous requests, macro off: both req high at T0 -> CPU served first (ack T3), DMA served next (ack T7); with CPU holding req, DMA is never served.
- Simultaneous requests, ROUND_ROBIN_EN: both req held continuously -> grants alternate CPU, DMA, CPU, DMA; acks at T3, T7, T11, T15.
- MEM_LATENCY=3 read: mem_rdata valid only in cycle ISSUE+3 -> captured value returned; ack in cycle 5 after the request is sampled.
- Reset in WAIT: rst_n low mid-read -> mem_en=0 and busy=0 immediately; no ack; after release, a new CPU read completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single-port memory with a fixed
// issue/wait/complete sequence. Define ROUND_ROBIN_EN for round-robin arbitration.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rW,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_rW,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_rW,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam int CNT_W = 3;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_rW_q, mem_rW_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_en_q, mem_en_d;
    logic              owner_q, owner_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              grant_dma;

`ifdef ROUND_ROBIN_EN
    logic last_q, last_d;  // last grant: 1 = DMA

    assign grant_dma = (cpu_req && dma_req) ? ~last_q : dma_req;
`else
    assign grant_dma = dma_req & ~cpu_req;
`endif

    always_comb begin
        // NOTE: every _d starts from its _q (or an explicit idle value) so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_address_d = mem_address_q;
        mem_rW_d      = mem_rW_q;
        mem_wdata_d   = mem_wdata_q;
        mem_en_d      = 1'b0;
        owner_d       = owner_q;
        cpu_ack_d     = 1'b0;
        dma_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
`ifdef ROUND_ROBIN_EN
        last_d        = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d       = grant_dma;
                    mem_address_d = grant_dma ? dma_addr  : cpu_addr;
                    mem_rW_d      = grant_dma ? dma_rW    : cpu_rW;
                    mem_wdata_d   = grant_dma ? dma_wdata : cpu_wdata;
                    mem_en_d      = 1'b1;
                    state_d       = ISSUE;
`ifdef ROUND_ROBIN_EN
                    last_d        = grant_dma;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Count of 1 marks cycle ISSUE+MEM_LATENCY, where mem_rdata is valid.
                if (cnt_q == CNT_W'(1)) begin
                    if (mem_rW_q) begin
                        if (owner_q) dma_rdata_d = mem_rdata;
                        else         cpu_rdata_d = mem_rdata;
                    end
                    cpu_ack_d = ~owner_q;
                    dma_ack_d = owner_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_address_q <= '0;
            mem_rW_q      <= 1'b1;
            mem_wdata_q   <= '0;
            mem_en_q      <= 1'b0;
            owner_q       <= 1'b0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
`ifdef ROUND_ROBIN_EN
            last_q        <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_address_q <= mem_address_d;
            mem_rW_q      <= mem_rW_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_en_q      <= mem_en_d;
            owner_q       <= owner_d;
            cpu_ack_q     <= cpu_ack_d;
            dma_ack_q     <= dma_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
`ifdef ROUND_ROBIN_EN
            last_q        <= last_d;
`endif
        end
    end

    assign mem_address = mem_address_q;
    assign mem_rW      = mem_rW_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_en      = mem_en_q;
    assign owner       = owner_q;
    assign cpu_ack     = cpu_ack_q;
    assign dma_ack     = dma_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dma_rdata   = dma_rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance at MEM_LATENCY=1 (both ports),
// one at MEM_LATENCY=3 (CPU port), each with a memory model that drives valid data only in cycle ISSUE+L.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit         port;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];

    // ---------------- instance with MEM_LATENCY = 1 ----------------
    logic        cpu_req = 0, cpu_rW = 1, dma_req = 0, dma_rW = 1;
    logic [15:0] cpu_addr = 0, dma_addr = 0;
    logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
    logic        cpu_ack, dma_ack, mem_rW, mem_en, owner, busy;
    logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_address;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rW(cpu_rW), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_rW(dma_rW), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_rW(mem_rW), .mem_wdata(mem_wdata),
        .mem_en(mem_en), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    logic [7:0] mem1 [256];
    int rc1 = 0;
    always @(posedge clk) begin
        if (mem_en) begin
            rc1 <= 1;
            if (!mem_rW) mem1[mem_address[7:0]] <= mem_wdata;
        end else if (rc1 != 0 && rc1 < 7) rc1 <= rc1 + 1;
    end
    assign mem_rdata = (rc1 == 1) ? mem1[mem_address[7:0]] : 8'hEE;

    // ---------------- instance with MEM_LATENCY = 3 ----------------
    logic        cpu_req3 = 0, cpu_rW3 = 1;
    logic [15:0] cpu_addr3 = 0;
    logic [7:0]  cpu_wdata3 = 0;
    logic        cpu_ack3, dma_ack3, mem_rW3, mem_en3, owner3, busy3;
    logic [7:0]  cpu_rdata3, dma_rdata3, mem_wdata3, mem_rdata3;
    logic [15:0] mem_address3;

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req3), .cpu_rW(cpu_rW3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .dma_req(1'b0), .dma_rW(1'b1), .dma_addr(16'h0000), .dma_wdata(8'h00),
        .dma_ack(dma_ack3), .dma_rdata(dma_rdata3),
        .mem_address(mem_address3), .mem_rW(mem_rW3), .mem_wdata(mem_wdata3),
        .mem_en(mem_en3), .mem_rdata(mem_rdata3), .owner(owner3), .busy(busy3)
    );

    logic [7:0] mem3 [256];
    int rc3 = 0;
    always @(posedge clk) begin
        if (mem_en3) begin
            rc3 <= 1;
            if (!mem_rW3) mem3[mem_address3[7:0]] <= mem_wdata3;
        end else if (rc3 != 0 && rc3 < 7) rc3 <= rc3 + 1;
    end
    assign mem_rdata3 = (rc3 == 3) ? mem3[mem_address3[7:0]] : 8'hEE;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ack || dma_ack) begin
                if (q1.size() == 0) check("l1_unexpected_ack", {30'd0, cpu_ack, dma_ack}, 0);
                else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("l1_ack_port", {30'd0, cpu_ack, dma_ack}, e.port ? 2'b01 : 2'b10);
                    check("l1_ack_cycle", cyc, e.cyc);
                    check("l1_rdata", e.port ? dma_rdata : cpu_rdata, e.rdata);
                end
            end
            if (cpu_ack3 || dma_ack3) begin
                if (q3.size() == 0) check("l3_unexpected_ack", {30'd0, cpu_ack3, dma_ack3}, 0);
                else begin
                    exp_t e;
                    e = q3.pop_front();
                    check("l3_ack_port", {30'd0, cpu_ack3, dma_ack3}, 2'b10);
                    check("l3_ack_cycle", cyc, e.cyc);
                    check("l3_rdata", cpu_rdata3, e.rdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic access1(input bit port, input bit rw, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
        int  t0;
        bit  seen;
        exp_t e;
        @(negedge clk);
        if (!port) begin
            cpu_req = 1; cpu_rW = rw; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            dma_req = 1; dma_rW = rw; dma_addr = addr; dma_wdata = wd;
        end
        t0 = cyc;
        e.port = port; e.rdata = exp_rd; e.cyc = t0 + 3;
        q1.push_back(e);
        @(negedge clk);
        check("l1_issue_en", mem_en, 1);
        check("l1_issue_addr", mem_address, addr);
        check("l1_issue_rw", mem_rW, rw);
        if (!rw) check("l1_issue_wdata", mem_wdata, wd);
        check("l1_owner", owner, port);
        @(negedge clk);
        check("l1_en_one_cycle", mem_en, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (port ? dma_ack : cpu_ack) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("l1_ack_timeout", 0, 1);
        cpu_req = 0;
        dma_req = 0;
    endtask

    task automatic access3(input bit rw, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
        int  t0;
        bit  seen;
        exp_t e;
        @(negedge clk);
        cpu_req3 = 1; cpu_rW3 = rw; cpu_addr3 = addr; cpu_wdata3 = wd;
        t0 = cyc;
        e.port = 0; e.rdata = exp_rd; e.cyc = t0 + 5;
        q3.push_back(e);
        @(negedge clk);
        check("l3_issue_en", mem_en3, 1);
        check("l3_issue_addr", mem_address3, addr);
        @(negedge clk);
        check("l3_en_one_cycle", mem_en3, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (cpu_ack3) seen = 1;
            else @(negedge clk);
        end
        if (!seen) check("l3_ack_timeout", 0, 1);
        cpu_req3 = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   t0;
        exp_t e;
        repeat (3) @(negedge clk);
        rst_n = 1;

        // Reset values.
        @(negedge clk);
        check("rst_mem_address", mem_address, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_mem_rW", mem_rW, 1);
        check("rst_mem_en", mem_en, 0);
        check("rst_acks", {30'd0, cpu_ack, dma_ack}, 0);
        check("rst_rdata", {16'd0, cpu_rdata, dma_rdata}, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);

        // Loader writes, CPU reads them back, DMA write leaves CPU rdata alone.
        access1(1, 0, 16'h0002, 8'h69, 8'h00);
        access1(0, 1, 16'h0002, 8'h00, 8'h69);
        access1(1, 0, 16'h0005, 8'h4C, 8'h00);
        check("cpu_rdata_kept", cpu_rdata, 8'h69);
        access1(1, 1, 16'hFF05, 8'h00, 8'h4C);
        access1(0, 0, 16'h0007, 8'h11, 8'h69);
        check("dma_rdata_kept", dma_rdata, 8'h4C);

        // Contention with both requests held: acks every 4 cycles.
        @(negedge clk);
        cpu_req = 1; cpu_rW = 1; cpu_addr = 16'h0002;
        dma_req = 1; dma_rW = 1; dma_addr = 16'h0005;
        t0 = cyc;
        e.port = 0; e.rdata = 8'h69; e.cyc = t0 + 3;  q1.push_back(e);
`ifdef ROUND_ROBIN_EN
        e.port = 1; e.rdata = 8'h4C; e.cyc = t0 + 7;  q1.push_back(e);
`else
        e.port = 0; e.rdata = 8'h69; e.cyc = t0 + 7;  q1.push_back(e);
`endif
        e.port = 0; e.rdata = 8'h69; e.cyc = t0 + 11; q1.push_back(e);
        e.port = 1; e.rdata = 8'h4C; e.cyc = t0 + 15; q1.push_back(e);
        repeat (11) @(negedge clk);
        cpu_req = 0;
        repeat (4) @(negedge clk);
        dma_req = 0;
        repeat (2) @(negedge clk);
        check("l1_queue_drained", q1.size(), 0);

        // MEM_LATENCY = 3 instance.
        access3(0, 16'h0010, 8'hA5, 8'h00);
        access3(1, 16'h0010, 8'h00, 8'hA5);
        access3(0, 16'h0020, 8'h3C, 8'hA5);
        access3(1, 16'h0020, 8'h00, 8'h3C);

        // Reset while the latency-3 read is in WAIT.
        @(negedge clk);
        cpu_req3 = 1; cpu_rW3 = 1; cpu_addr3 = 16'h0010;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy3, 1);
        #2;
        rst_n = 0;
        cpu_req3 = 0;
        #1;
        check("rst_wait_busy", busy3, 0);
        check("rst_wait_mem_en", mem_en3, 0);
        check("rst_wait_mem_rW", mem_rW3, 1);
        check("rst_wait_addr", mem_address3, 16'h0000);
        check("rst_wait_rdata3", cpu_rdata3, 8'h00);
        check("rst_wait_rdata1", cpu_rdata, 8'h00);
        check("rst_wait_ack", {30'd0, cpu_ack3, dma_ack3}, 0);
        @(negedge clk);
        rst_n = 1;
        access3(1, 16'h0010, 8'h00, 8'hA5);
        access1(0, 1, 16'h0002, 8'h00, 8'h69);

        repeat (4) @(negedge clk);
        check("l1_queue_final", q1.size(), 0);
        check("l3_queue_final", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
